// File: rtl/spike_dispatcher.sv
// Spike dispatcher: pops one pre-synaptic address from the spike FIFO and expands it into N
// synaptic events (pre, post=0..N-1). Optional spike counter under `SPIKE_DISPATCH_PERF_EN`.
module spike_dispatcher #(
  parameter int unsigned N     = 256,
  parameter int unsigned CNT_W = 32,
  localparam int unsigned AW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          DISPATCH_en_i,
  input  logic          FIFO_empty_i,
  output logic          FIFO_r_en_o,
  input  logic [AW-1:0] FIFO_r_data_i,
  output logic          EVT_valid_o,
  input  logic          EVT_ready_i,
  output logic [AW-1:0] EVT_pre_o,
  output logic [AW-1:0] EVT_post_o,
  output logic          EVT_last_o,
  output logic          BUSY_o
`ifdef SPIKE_DISPATCH_PERF_EN
  ,
  output logic [CNT_W-1:0] SPK_cnt_o
`endif
);

  if (N < 2) begin : g_n_check
    $error("spike_dispatcher: N must be >= 2");
  end
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("spike_dispatcher: CNT_W must be >= 1");
  end

  localparam logic [AW-1:0] PostLast = AW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDispatch
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pre_q, pre_d;
  logic [AW-1:0] post_q, post_d;
  logic          post_is_last;
  logic          evt_fire;

  assign post_is_last = (post_q == PostLast);
  assign evt_fire     = EVT_valid_o & EVT_ready_i;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (FIFO_r_en_o) begin
          state_d = StWait;
        end
      end
      StWait: begin
        state_d = StDispatch;
      end
      StDispatch: begin
        if (evt_fire && post_is_last) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode; the pop strobe is the only output that looks at inputs
  always_comb begin
    FIFO_r_en_o = 1'b0;
    EVT_valid_o = 1'b0;
    EVT_last_o  = 1'b0;
    BUSY_o      = 1'b0;
    unique case (state_q)
      StIdle: begin
        FIFO_r_en_o = DISPATCH_en_i & ~FIFO_empty_i;
      end
      StWait: begin
        BUSY_o = 1'b1;
      end
      StDispatch: begin
        BUSY_o      = 1'b1;
        EVT_valid_o = 1'b1;
        EVT_last_o  = post_is_last;
      end
      default: begin
        BUSY_o = 1'b0;
      end
    endcase
  end

  // FIFO read data is registered, so it is captured in the cycle after the pop
  always_comb begin
    pre_d  = pre_q;
    post_d = post_q;
    if (state_q == StWait) begin
      pre_d  = FIFO_r_data_i;
      post_d = '0;
    end else if (evt_fire && !post_is_last) begin
      post_d = post_q + AW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_q  <= '0;
      post_q <= '0;
    end else begin
      pre_q  <= pre_d;
      post_q <= post_d;
    end
  end

  assign EVT_pre_o  = pre_q;
  assign EVT_post_o = post_q;

`ifdef SPIKE_DISPATCH_PERF_EN
  logic [CNT_W-1:0] spk_cnt_q, spk_cnt_d;

  always_comb begin
    spk_cnt_d = spk_cnt_q;
    if (evt_fire && EVT_last_o) begin
      spk_cnt_d = spk_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      spk_cnt_q <= '0;
    end else begin
      spk_cnt_q <= spk_cnt_d;
    end
  end

  assign SPK_cnt_o = spk_cnt_q;
`endif

endmodule
